// File: rtl/rr_burst_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter and its helpers.
// Contents:
//   arb_state_t : output ownership state (idle / locked to one channel)
//   idx_w()     : width of a channel index; never narrower than 1 bit
//   slice()     : extract word c from a packed multi-channel bus
package rr_burst_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned MAX_CH = 32;
   localparam int unsigned MAX_DW = 64;

   function automatic logic [MAX_DW-1:0] slice(input logic [MAX_CH*MAX_DW-1:0] bus,
                                                input int unsigned c,
                                                input int unsigned dw);
      logic [MAX_DW-1:0] w;
      w = '0;
      for (int unsigned b = 0; b < MAX_DW; b++) begin
         if (b < dw) w[b] = bus[c*dw + b];
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Channel-side and stream-side signals of the round-robin burst arbiter.
// slave  : arbiter view (request/data/config in, grant/stream out)
// master : environment view (drives requests, consumes the merged stream)
//   WRITE_REQ  channel has a word        HOLD_REQ  channel keeps ownership
//   DATA_IN    packed channel words      CH_ENABLE run-time channel mask
//   BURST_LEN  words per grant (0 -> 1)  READY_OUT downstream accepts
//   READ_GRANT one-hot pop strobe        WRITE_OUT stream word valid/taken
//   DATA_OUT   stream word               GRANT_ID  last owner index
//   LOCKED     a channel owns the output
interface rr_burst_arbiter_if
   import rr_burst_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH      = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_W    = 4
);
   localparam int unsigned IDW = idx_w(WIDTH);

   logic [WIDTH-1:0]            WRITE_REQ;
   logic [WIDTH-1:0]            HOLD_REQ;
   logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
   logic [WIDTH-1:0]            CH_ENABLE;
   logic [BURST_W-1:0]          BURST_LEN;
   logic                        READY_OUT;
   logic [WIDTH-1:0]            READ_GRANT;
   logic                        WRITE_OUT;
   logic [DATA_WIDTH-1:0]       DATA_OUT;
   logic [IDW-1:0]              GRANT_ID;
   logic                        LOCKED;

   modport slave (
      input  WRITE_REQ, HOLD_REQ, DATA_IN, CH_ENABLE, BURST_LEN, READY_OUT,
      output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, LOCKED
   );

   modport master (
      output WRITE_REQ, HOLD_REQ, DATA_IN, CH_ENABLE, BURST_LEN, READY_OUT,
      input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, LOCKED
   );

endinterface

// File: rtl/rr_burst_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of elig_i searching
// upward from ptr_i+1 with wrap-around.
//   elig_i : eligible channels
//   ptr_i  : last served channel
//   pick_o : index of next channel to serve (0 when none)
//   any_o  : at least one channel eligible
module rr_pick
   import rr_burst_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   localparam int unsigned IDW  = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] elig_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic [IDW-1:0]   pick_o,
   output logic             any_o
);

   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] masked;

   // Duplicating the request vector turns the wrapped search into a plain
   // lowest-set-bit search above ptr_i; the window ptr+1..ptr+WIDTH always
   // contains one copy of every channel.
   always_comb begin
      dbl    = {elig_i, elig_i};
      masked = '0;
      for (int unsigned i = 0; i < 2*WIDTH; i++) begin
         if (i > 32'(ptr_i)) masked[i] = dbl[i];
      end
      pick_o = '0;
      for (int unsigned i = 2*WIDTH; i > 0; i--) begin
         if (masked[i-1]) pick_o = IDW'((i-1) % WIDTH);
      end
      any_o = |elig_i;
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin merge of WIDTH first-word-fall-through channel FIFOs into one
// stream. Grants last up to BURST_LEN words; HOLD_REQ extends ownership to
// keep multi-word records atomic; a new owner is picked in the same cycle
// the previous one releases, so back-to-back bursts have no bubble.
//   BUS_CLK : clock, all state on rising edge
//   BUS_RST : asynchronous active-high reset
//   bus     : channel requests/data/config in, grant and merged stream out
module rr_burst_arbiter
   import rr_burst_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH      = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_W    = 4
) (
   input  logic               BUS_CLK,
   input  logic               BUS_RST,
   rr_burst_arbiter_if.slave  bus
);

   localparam int unsigned        IDW     = idx_w(WIDTH);
   localparam logic [BURST_W-1:0] CNT_MAX = '1;

   arb_state_t          state_q, state_d;
   logic [IDW-1:0]      owner_q, owner_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [IDW-1:0]      gid_q, gid_d;
   logic [BURST_W-1:0]  count_q, count_d;

   logic [WIDTH-1:0]      elig;
   logic [IDW-1:0]        pick;
   logic                  any;
   logic                  locked;
   logic [IDW-1:0]        active;
   logic                  valid;
   logic                  xfer;
   logic [BURST_W-1:0]    len;
   logic [BURST_W:0]      count_inc;
   logic                  burst_end;
   logic [DATA_WIDTH-1:0] word;

   rr_pick #(.WIDTH(WIDTH)) u_pick (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .pick_o (pick),
      .any_o  (any)
   );

   always_comb begin
      elig      = bus.WRITE_REQ & bus.CH_ENABLE;
      locked    = (state_q == ST_LOCKED);
      active    = locked ? owner_q : pick;
      valid     = locked ? elig[owner_q] : any;
      xfer      = valid & bus.READY_OUT & ~BUS_RST;
      len       = (bus.BURST_LEN == '0) ? BURST_W'(1) : bus.BURST_LEN;
      // One extra bit so a saturated counter still reaches the burst end.
      count_inc = {1'b0, count_q} + {{BURST_W{1'b0}}, 1'b1};
      burst_end = (count_inc >= {1'b0, len}) & ~bus.HOLD_REQ[active];
      word      = '0;
      for (int unsigned c = 0; c < WIDTH; c++) begin
         if (active == IDW'(c)) word = bus.DATA_IN[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.WRITE_OUT  = xfer;
   assign bus.READ_GRANT = xfer ? (WIDTH'(1) << active) : '0;
   assign bus.DATA_OUT   = (valid & ~BUS_RST) ? word : '0;
   assign bus.GRANT_ID   = gid_q;
   assign bus.LOCKED     = locked;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      count_d = count_q;
      if (xfer) begin
         gid_d = active;
         if (burst_end) begin
            state_d = ST_IDLE;
            count_d = '0;
            ptr_d   = active;
         end else begin
            state_d = ST_LOCKED;
            owner_d = active;
            count_d = (count_q == CNT_MAX) ? count_q : count_inc[BURST_W-1:0];
         end
      end else if (locked &&
                   (!bus.CH_ENABLE[owner_q] ||
                    (!elig[owner_q] && !bus.HOLD_REQ[owner_q]))) begin
         // A disabled owner is dropped even mid-record; an owner with no data
         // and no record in progress gives way to the others.
         state_d = ST_IDLE;
         count_d = '0;
         ptr_d   = owner_q;
      end
   end

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= IDW'(WIDTH-1);
         gid_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;
   import rr_burst_arbiter_pkg::*;

   localparam int W  = 5;
   localparam int DW = 32;
   localparam int BW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rr_burst_arbiter_if #(.WIDTH(W), .DATA_WIDTH(DW), .BURST_W(BW)) bus();

   rr_burst_arbiter #(.WIDTH(W), .DATA_WIDTH(DW), .BURST_W(BW)) dut (
      .BUS_CLK (clk),
      .BUS_RST (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   // Channel FIFOs: word = {channel, sequence}; popped by READ_GRANT.
   int unsigned fifo_seq[W] = '{default: 0};
   int unsigned mseq[W]     = '{default: 0};

   for (genvar g = 0; g < W; g++) begin : g_data
      assign bus.DATA_IN[g*DW +: DW] = {8'(g), fifo_seq[g][23:0]};
   end

   always @(posedge clk) begin
      for (int c = 0; c < W; c++)
         if (bus.READ_GRANT[c]) fifo_seq[c] <= fifo_seq[c] + 1;
   end

   task automatic chk_v(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_locked = 0;
   int m_owner = 0, m_count = 0, m_ptr = W-1, m_gid = 0;
   bit nx_locked, nx_xfer;
   int nx_owner, nx_count, nx_ptr, nx_gid, nx_act;

   function automatic int pick_fn(input logic [W-1:0] e, input int ptr);
      for (int k = 1; k <= W; k++)
         if (e[(ptr+k) % W]) return (ptr+k) % W;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         logic [W-1:0]  e;
         logic [W-1:0]  eg;
         logic [DW-1:0] ed;
         int act, len, exp_gid;
         bit v, x, exp_lk;
         e  = bus.WRITE_REQ & bus.CH_ENABLE;
         act = 0; v = 0; x = 0; eg = '0; ed = '0;
         nx_locked = m_locked; nx_owner = m_owner; nx_count = m_count;
         nx_ptr = m_ptr; nx_gid = m_gid; nx_xfer = 0; nx_act = 0;
         if (rst) begin
            exp_gid = 0; exp_lk = 0;
            nx_locked = 0; nx_owner = 0; nx_count = 0; nx_ptr = W-1; nx_gid = 0;
         end else begin
            exp_gid = m_gid; exp_lk = m_locked;
            if (m_locked) begin act = m_owner; v = e[act]; end
            else begin v = (e != 0); act = pick_fn(e, m_ptr); end
            x = v && bus.READY_OUT;
            if (x) eg = W'(1) << act;
            if (v) ed = {8'(act), mseq[act][23:0]};
            nx_xfer = x; nx_act = act;
            len = (bus.BURST_LEN == 0) ? 1 : int'(bus.BURST_LEN);
            if (x) begin
               nx_gid = act;
               if (m_count + 1 >= len && !bus.HOLD_REQ[act]) begin
                  nx_locked = 0; nx_count = 0; nx_ptr = act;
               end else begin
                  nx_locked = 1; nx_owner = act;
                  nx_count = (m_count == 2**BW - 1) ? m_count : m_count + 1;
               end
            end else if (m_locked && (!bus.CH_ENABLE[m_owner] ||
                                      (!e[m_owner] && !bus.HOLD_REQ[m_owner]))) begin
               nx_locked = 0; nx_count = 0; nx_ptr = m_owner;
            end
         end
         chk_v("grant",    bus.READ_GRANT, eg);
         chk_v("write",    bus.WRITE_OUT, x);
         chk_v("data",     bus.DATA_OUT, ed);
         chk_v("grant_id", bus.GRANT_ID, exp_gid);
         chk_v("locked",   bus.LOCKED, exp_lk);
         chk_v("grant_enabled", bus.READ_GRANT & ~bus.CH_ENABLE, 0);
         chk_v("onehot",   ($countones(bus.READ_GRANT) <= 1), 1);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_locked <= 0; m_owner <= 0; m_count <= 0; m_ptr <= W-1; m_gid <= 0;
      end else if (armed) begin
         m_locked <= nx_locked; m_owner <= nx_owner; m_count <= nx_count;
         m_ptr <= nx_ptr; m_gid <= nx_gid;
         if (nx_xfer) mseq[nx_act] <= mseq[nx_act] + 1;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic cyc(input string nm, input bit exp_wr, input int exp_ch, input bit exp_lk);
      @(negedge clk);
      chk_v({nm, "_wr"},  bus.WRITE_OUT, exp_wr);
      chk_v({nm, "_gnt"}, bus.READ_GRANT, exp_wr ? (64'd1 << exp_ch) : 64'd0);
      chk_v({nm, "_lk"},  bus.LOCKED, exp_lk);
      if (exp_ch >= 0) chk_v({nm, "_tag"}, bus.DATA_OUT[31:24], exp_ch);
      @(posedge clk); #1;
   endtask

   task automatic rst_chk(input string nm);
      @(negedge clk);
      chk_v({nm, "_gnt"},  bus.READ_GRANT, 0);
      chk_v({nm, "_wr"},   bus.WRITE_OUT, 0);
      chk_v({nm, "_data"}, bus.DATA_OUT, 0);
      chk_v({nm, "_gid"},  bus.GRANT_ID, 0);
      chk_v({nm, "_lk"},   bus.LOCKED, 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      rst_chk(nm);
      rst = 1'b0;
   endtask

   initial begin
      bus.WRITE_REQ = 5'h1F; bus.HOLD_REQ = '0; bus.CH_ENABLE = 5'h1F;
      bus.BURST_LEN = 4'd3;  bus.READY_OUT = 1'b1;
      @(posedge clk); #1;
      armed = 1'b1;

      // Reset, including a pulse mid-burst
      rst_chk("rst_hold");
      rst = 1'b0;
      cyc("t1a", 1, 0, 0); cyc("t1b", 1, 0, 1);
      do_reset("rst_mid");
      cyc("t1c", 1, 0, 0); cyc("t1d", 1, 0, 1); cyc("t1e", 1, 0, 1); cyc("t1f", 1, 1, 0);

      // Single-word rotation
      bus.BURST_LEN = 4'd1;
      do_reset("rst2");
      cyc("rot0", 1, 0, 0); cyc("rot1", 1, 1, 0); cyc("rot2", 1, 2, 0);
      cyc("rot3", 1, 3, 0); cyc("rot4", 1, 4, 0); cyc("rot5", 1, 0, 0); cyc("rot6", 1, 1, 0);

      // Bursts of 3 on ch1/ch3, then BURST_LEN=0
      bus.WRITE_REQ = 5'b01010; bus.BURST_LEN = 4'd3;
      do_reset("rst3");
      cyc("b1a", 1, 1, 0); cyc("b1b", 1, 1, 1); cyc("b1c", 1, 1, 1);
      cyc("b3a", 1, 3, 0); cyc("b3b", 1, 3, 1); cyc("b3c", 1, 3, 1);
      bus.BURST_LEN = 4'd0;
      cyc("z1", 1, 1, 0); cyc("z3", 1, 3, 0); cyc("z1b", 1, 1, 0); cyc("z3b", 1, 3, 0);

      // Hold keeps ch2 across a gap; ch0 waits
      bus.WRITE_REQ = 5'b00100; bus.HOLD_REQ = 5'b00100; bus.BURST_LEN = 4'd2;
      do_reset("rst4");
      cyc("h1", 1, 2, 0);
      bus.WRITE_REQ = 5'b00101;
      cyc("h2", 1, 2, 1);
      bus.WRITE_REQ = 5'b00001;
      cyc("hgap1", 0, -1, 1); cyc("hgap2", 0, -1, 1);
      bus.WRITE_REQ = 5'b00101;
      cyc("h3", 1, 2, 1); cyc("h4", 1, 2, 1);
      bus.HOLD_REQ = '0;
      cyc("h5", 1, 2, 1); cyc("h6", 1, 0, 0); cyc("h7", 1, 0, 1);

      // Mask release, then back-pressure mid-burst
      bus.WRITE_REQ = 5'b01100; bus.HOLD_REQ = 5'b00100; bus.BURST_LEN = 4'd1;
      do_reset("rst5");
      cyc("m1", 1, 2, 0); cyc("m2", 1, 2, 1);
      bus.CH_ENABLE = 5'b11011;
      cyc("m_rel", 0, -1, 1); cyc("m3", 1, 3, 0);
      bus.CH_ENABLE = 5'h1F; bus.HOLD_REQ = '0; bus.BURST_LEN = 4'd3;
      cyc("bp1", 1, 2, 0); cyc("bp2", 1, 2, 1);
      bus.READY_OUT = 1'b0;
      for (int i = 0; i < 4; i++) cyc("bp_stall", 0, 2, 1);
      bus.READY_OUT = 1'b1;
      cyc("bp3", 1, 2, 1); cyc("bp4", 1, 3, 0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bus.WRITE_REQ = W'($urandom);
         bus.HOLD_REQ  = W'($urandom & $urandom & $urandom);
         bus.CH_ENABLE = ($urandom_range(0, 7) == 0) ? W'($urandom) : 5'h1F;
         bus.READY_OUT = ($urandom_range(0, 3) != 0);
         bus.BURST_LEN = BW'($urandom_range(0, 4));
         @(posedge clk); #1;
      end
      bus.WRITE_REQ = '0; bus.HOLD_REQ = '0;
      repeat (2) begin @(posedge clk); #1; end

      for (int c = 0; c < W; c++) chk_v($sformatf("words_ch%0d", c), fifo_seq[c], mseq[c]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
